// File: rtl/texture_fetch_arbiter.sv
// texture_fetch_arbiter
//   Round-robin arbiter that shares the texture memory read port between
//   N_REQ fetch requesters. It holds off requests whose index matches the
//   block the upload path is currently writing. It tracks in-flight reads in
//   a tag pipeline that matches the memory latency, so each returned block is
//   steered to the requester that asked for it.
//
// Ports
//   clk          : clock, all state on rising edge
//   rst_n        : asynchronous active-low reset
//   i_req_valid  : [N_REQ]    per-requester request valid
//   i_req_idx    : [8*N_REQ]  texture index, requester k at [8k+7:8k]
//   o_req_ready  : [N_REQ]    one-hot grant (combinational)
//   i_lock_valid : upload path is rewriting block i_lock_idx
//   i_lock_idx   : [8]        block being rewritten
//   o_mem_idx    : [8]        registered read index to texture memory
//   i_mem_data   : [2048]     block returned by memory
//   o_rsp_valid  : [N_REQ]    one-hot single-cycle response strobe
//   o_rsp_data   : [2048]     i_mem_data passed straight through
//   o_busy       : reads in flight or any request pending
module texture_fetch_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [8*N_REQ-1:0]   i_req_idx,
    output logic [N_REQ-1:0]     o_req_ready,
    input  logic                 i_lock_valid,
    input  logic [7:0]           i_lock_idx,
    output logic [7:0]           o_mem_idx,
    input  logic [2047:0]        i_mem_data,
    output logic [N_REQ-1:0]     o_rsp_valid,
    output logic [2047:0]        o_rsp_data,
    output logic                 o_busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    ptr;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic             grant_any;
    logic [PW-1:0]    win;
    logic [7:0]       win_idx;

    logic [MEM_LAT:0] tag_v;
    logic [N_REQ-1:0] tag_id [MEM_LAT+1];

    // Memory decodes only 7 index bits, so bit 7 is masked out of the lock
    // compare: 8'h85 and 8'h05 address the same physical block.
    always_comb begin
        eligible = '0;
        for (int k = 0; k < N_REQ; k++) begin
            eligible[k] = i_req_valid[k] &&
                !(i_lock_valid && (((i_req_idx[8*k +: 8] ^ i_lock_idx) & 8'h7f) == 8'h00));
        end
    end

    // Search begins one past the last winner and wraps.
    always_comb begin
        int cand;
        grant_any = 1'b0;
        win       = ptr;
        cand      = 0;
        for (int s = 1; s <= N_REQ; s++) begin
            cand = int'(ptr) + s;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                win       = PW'(cand);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (grant_any) grant[win] = 1'b1;
    end

    assign win_idx     = i_req_idx[8*int'(win) +: 8];
    assign o_req_ready = rst_n ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= PW'(N_REQ - 1);
            o_mem_idx <= 8'h00;
        end else if (grant_any) begin
            ptr       <= win;
            o_mem_idx <= win_idx;
        end
    end

    // Stage 0 holds the grant from the previous cycle; stage MEM_LAT lines up
    // with the cycle the memory presents the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int i = 0; i <= MEM_LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_v[0]  <= grant_any;
            tag_id[0] <= grant;
            for (int i = 1; i <= MEM_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign o_rsp_valid = tag_v[MEM_LAT] ? tag_id[MEM_LAT] : '0;
    assign o_rsp_data  = i_mem_data;
    assign o_busy      = (|tag_v) || (|i_req_valid);

endmodule

// File: tb/tb_texture_fetch_arbiter.sv
module tb_texture_fetch_arbiter;

    localparam int N   = 4;
    localparam int LAT = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_idx;
    logic [N-1:0]   req_ready;
    logic           lock_valid;
    logic [7:0]     lock_idx;
    logic [7:0]     mem_idx;
    logic [2047:0]  mem_data;
    logic [N-1:0]   rsp_valid;
    logic [2047:0]  rsp_data;
    logic           busy;

    int total = 0;
    int bad   = 0;

    texture_fetch_arbiter #(.N_REQ(N), .MEM_LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_req_idx   (req_idx),
        .o_req_ready (req_ready),
        .i_lock_valid(lock_valid),
        .i_lock_idx  (lock_idx),
        .o_mem_idx   (mem_idx),
        .i_mem_data  (mem_data),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2047:0] blk(input logic [7:0] x);
        logic [2047:0] r;
        r = '0;
        for (int j = 0; j < 256; j++) r[j*8 +: 8] = x ^ 8'(j);
        return r;
    endfunction

    // Texture memory model: index presented in cycle c, block out in c+LAT.
    logic [7:0] mem_q [LAT];
    always @(posedge clk) begin
        mem_q[0] <= mem_idx;
        for (int i = 1; i < LAT; i++) mem_q[i] <= mem_q[i-1];
    end
    assign mem_data = blk(mem_q[LAT-1]);

    task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, row, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [31:0] idx;
        logic        lv;
        logic [7:0]  li;
        logic [3:0]  er;
        logic [7:0]  em;
        logic [3:0]  erp;
        logic [7:0]  eri;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [3:0] rv, logic [31:0] idx, logic lv, logic [7:0] li,
                                logic [3:0] er, logic [7:0] em, logic [3:0] erp, logic [7:0] eri);
        vec_t v;
        v.rst = rst; v.rv = rv; v.idx = idx; v.lv = lv; v.li = li;
        v.er = er; v.em = em; v.erp = erp; v.eri = eri;
        return v;
    endfunction

    typedef struct {
        int         due;
        int         id;
        logic [7:0] idx;
    } pend_t;

    pend_t      pend[$];
    int         m_last;
    logic [7:0] m_mem;
    int         cyc;

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_idx    = '0;
        lock_valid = 1'b0;
        lock_idx   = 8'h00;

        // rst, valid, idx{3,2,1,0}, lock, lock_idx, ready, mem_idx, rsp_valid, rsp block
        tbl.push_back(mk(0, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h00, 4'b0000, 8'h00));
        // single request
        tbl.push_back(mk(1, 4'b0100, 32'h00150000, 0, 8'h00, 4'b0100, 8'h00, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h15, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h15, 4'b0100, 8'h15));
        // all four from reset
        tbl.push_back(mk(0, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h00, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b1111, 32'h13121110, 0, 8'h00, 4'b0001, 8'h00, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b1110, 32'h13121110, 0, 8'h00, 4'b0010, 8'h10, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b1100, 32'h13121110, 0, 8'h00, 4'b0100, 8'h11, 4'b0001, 8'h10));
        tbl.push_back(mk(1, 4'b1000, 32'h13121110, 0, 8'h00, 4'b1000, 8'h12, 4'b0010, 8'h11));
        tbl.push_back(mk(1, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h13, 4'b0100, 8'h12));
        tbl.push_back(mk(1, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h13, 4'b1000, 8'h13));
        // fairness: grant 1, then 0 and 3 together -> 3 first
        tbl.push_back(mk(1, 4'b0010, 32'h00002100, 0, 8'h00, 4'b0010, 8'h13, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b1001, 32'h33000030, 0, 8'h00, 4'b1000, 8'h21, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b0001, 32'h00000030, 0, 8'h00, 4'b0001, 8'h33, 4'b0010, 8'h21));
        tbl.push_back(mk(1, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h30, 4'b1000, 8'h33));
        tbl.push_back(mk(1, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h30, 4'b0001, 8'h30));
        // lock on 8'h85 blocks idx 8'h05 (7-bit compare)
        tbl.push_back(mk(1, 4'b0011, 32'h00000605, 1, 8'h85, 4'b0010, 8'h30, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b0001, 32'h00000005, 0, 8'h85, 4'b0001, 8'h06, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h05, 4'b0010, 8'h06));
        tbl.push_back(mk(1, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h05, 4'b0001, 8'h05));
        // back-to-back on requester 3
        tbl.push_back(mk(1, 4'b1000, 32'h40000000, 0, 8'h00, 4'b1000, 8'h05, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b1000, 32'h41000000, 0, 8'h00, 4'b1000, 8'h40, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b1000, 32'h42000000, 0, 8'h00, 4'b1000, 8'h41, 4'b1000, 8'h40));
        tbl.push_back(mk(1, 4'b1000, 32'h43000000, 0, 8'h00, 4'b1000, 8'h42, 4'b1000, 8'h41));
        tbl.push_back(mk(1, 4'b1000, 32'h44000000, 0, 8'h00, 4'b1000, 8'h43, 4'b1000, 8'h42));
        tbl.push_back(mk(1, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h44, 4'b1000, 8'h43));
        tbl.push_back(mk(1, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h44, 4'b1000, 8'h44));
        // reset mid-flight, requests pending during reset
        tbl.push_back(mk(1, 4'b0010, 32'h00005100, 0, 8'h00, 4'b0010, 8'h44, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h51, 4'b0000, 8'h00));
        tbl.push_back(mk(0, 4'b0110, 32'h00525100, 0, 8'h00, 4'b0000, 8'h00, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b0110, 32'h00525100, 0, 8'h00, 4'b0010, 8'h00, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h51, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b0000, 32'h00000000, 0, 8'h00, 4'b0000, 8'h51, 4'b0010, 8'h51));

        @(posedge clk); #1;
        for (int r = 0; r < tbl.size(); r++) begin
            rst_n      = tbl[r].rst;
            req_valid  = tbl[r].rv;
            req_idx    = tbl[r].idx;
            lock_valid = tbl[r].lv;
            lock_idx   = tbl[r].li;
            @(negedge clk);
            chk("ready", r, 64'(req_ready), 64'(tbl[r].er));
            chk("mem_idx", r, 64'(mem_idx), 64'(tbl[r].em));
            chk("rsp_valid", r, 64'(rsp_valid), 64'(tbl[r].erp));
            if (tbl[r].erp != 4'b0000)
                chk("rsp_data", r, 64'(rsp_data === blk(tbl[r].eri)), 64'd1);
            @(posedge clk); #1;
        end

        // Randomized run against a transaction-level model.
        pend.delete();
        m_last = N - 1;
        m_mem  = 8'h00;
        cyc    = 0;
        for (int r = 0; r < 600; r++) begin
            logic [N-1:0] exp_ready;
            logic [N-1:0] exp_rsp;
            int           w;
            rst_n      = (r == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
            req_valid  = N'($urandom);
            for (int k = 0; k < N; k++)
                req_idx[8*k +: 8] = {1'($urandom), 7'($urandom_range(0, 7))};
            lock_valid = ($urandom_range(0, 2) == 0);
            lock_idx   = {1'($urandom), 7'($urandom_range(0, 7))};
            @(negedge clk);
            if (!rst_n) begin
                pend.delete();
                m_last = N - 1;
                m_mem  = 8'h00;
            end
            exp_ready = '0;
            w = -1;
            if (rst_n) begin
                for (int s = 1; s <= N; s++) begin
                    int c;
                    c = (m_last + s) % N;
                    if (w < 0 && req_valid[c] &&
                        !(lock_valid && req_idx[8*c +: 7] == lock_idx[6:0])) w = c;
                end
                if (w >= 0) exp_ready[w] = 1'b1;
            end
            exp_rsp = '0;
            if (pend.size() > 0 && pend[0].due == cyc) exp_rsp[pend[0].id] = 1'b1;
            chk("rnd_ready", r, 64'(req_ready), 64'(exp_ready));
            chk("rnd_mem_idx", r, 64'(mem_idx), 64'(m_mem));
            chk("rnd_rsp_valid", r, 64'(rsp_valid), 64'(exp_rsp));
            chk("rnd_busy", r, 64'(busy), 64'((|req_valid) || (pend.size() > 0)));
            if (exp_rsp != '0) begin
                chk("rnd_rsp_data", r, 64'(rsp_data === blk(pend[0].idx)), 64'd1);
                void'(pend.pop_front());
            end
            if (w >= 0) begin
                pend_t p;
                p.due = cyc + 1 + LAT;
                p.id  = w;
                p.idx = req_idx[8*w +: 8];
                pend.push_back(p);
                m_last = w;
                m_mem  = req_idx[8*w +: 8];
            end
            cyc++;
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/texture_fetch_arbiter.md
# texture_fetch_arbiter

Shares the single read port of the texture memory between `N_REQ` texture-fetch requesters. Each cycle it grants at most one request by round-robin, drives the memory read index, and routes the returned 2048-bit texture block back to the winning requester. It tracks in-flight reads through a tag pipeline matched to the memory read latency. It also holds off reads of a texture block that the upload path is currently rewriting.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `MEM_LAT`, 1: memory read latency in cycles, from index presented to data valid (1..3).

Ports:
- `clk` in 1: the single clock; all state is on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_req_valid` in N_REQ: per-requester request valid.
- `i_req_idx` in 8*N_REQ: texture index; requester k uses bits [8k+7:8k].
- `o_req_ready` out N_REQ: one-hot grant. A handshake completes when valid and ready are both high.
- `i_lock_valid` in 1: upload path is writing the block at `i_lock_idx`.
- `i_lock_idx` in 8: texture index being written.
- `o_mem_idx` out 8: read index to the texture memory, registered.
- `i_mem_data` in 2048: texture block from the memory.
- `o_rsp_valid` out N_REQ: one-hot response strobe, single cycle.
- `o_rsp_data` out 2048: equals `i_mem_data` combinationally; meaningful only while `o_rsp_valid` is non-zero.
- `o_busy` out 1: any read is in flight, or any `i_req_valid` is high.

## Operation
- Eligibility of requester k: `i_req_valid[k]`, and NOT (`i_lock_valid` and `i_req_idx[k][6:0] == i_lock_idx[6:0]`).
  - The compare uses bits [6:0] only, because the memory decodes 7 index bits.
- Arbitration is combinational within the cycle.
  - Search starts at `(ptr+1) mod N_REQ` and wraps; the first eligible requester wins.
  - Drive `o_req_ready[win]` = 1 and all other ready bits 0.
  - No eligible requester: `o_req_ready` = 0.
- Pointer `ptr` (log2 N_REQ bits) updates to `win` only on a grant; otherwise it holds.
- On a grant, the requester's index is registered into `o_mem_idx` at the next edge. With no grant, `o_mem_idx` holds its previous value.
- Tag pipeline: a shift register of depth `1+MEM_LAT` carrying {valid, one-hot id}.
  - A grant enters stage 0.
  - The last stage drives `o_rsp_valid`.
- Responses have no backpressure; requesters must accept `o_rsp_valid` unconditionally.
- Throughput is one grant per cycle. Responses return in grant order.
- Requester contract: `i_req_idx` is stable while valid and not ready. The arbiter itself does not depend on this.
- A lock asserted in the same cycle as a request to that index blocks that request in the same cycle. A lock asserted after a grant does not cancel the in-flight read; the upload path must quiesce before locking.
- A blocked requester never blocks other requesters.

## Timing
- Reset values (asynchronous, all immediate):
  - `o_req_ready` = 0.
  - `o_mem_idx` = 8'h00.
  - `ptr` = N_REQ-1, so requester 0 has first priority.
  - Tag pipeline cleared.
  - `o_rsp_valid` = 0.
  - `o_busy` = 0 if no request is valid.
- `o_req_ready` is also forced to 0 while `rst_n` is low.
- Grant in cycle t:
  - `o_mem_idx` is valid in cycle t+1.
  - `i_mem_data` is valid in cycle t+1+MEM_LAT.
  - `o_rsp_valid[win]` is high in cycle t+1+MEM_LAT (t+2 at default).
- Reset mid-operation: in-flight reads are discarded and produce no response. The first grant after release goes to the lowest-numbered eligible requester.
- Response strobes never overlap; at most one bit of `o_rsp_valid` is high per cycle.
- `o_busy` falls in the cycle after the last `o_rsp_valid`, provided no requests are valid.

## Test plan
- Single request: req 2 with idx 8'h15 in cycle 0.
  - Expect `o_req_ready`=4'b0100 in cycle 0.
  - Expect `o_mem_idx`=8'h15 in cycle 1.
  - Expect `o_rsp_valid`=4'b0100 in cycle 2, with `o_rsp_data` equal to the model block 0x15.
- All four requesters valid from reset, each held until granted, idx 0x10..0x13.
  - Expect grants in order 0,1,2,3 in cycles 0..3.
  - Expect responses in the same order in cycles 2..5, each with the correct block.
- Fairness: after a grant to 1, requesters 0 and 3 go valid together. Expect 3 granted, then 0.
- Lock: `i_lock_valid`=1 with `i_lock_idx`=8'h85; req 0 idx 8'h05 and req 1 idx 8'h06 valid.
  - Only req 1 is granted, and req 0 is held.
  - Release the lock: req 0 is granted the next cycle.
- Back-to-back: only req 3 valid for 5 cycles with changing idx.
  - Expect 5 consecutive grants.
  - Expect 5 consecutive responses starting 2 cycles later.
  - Verify `o_mem_idx` sequence and data match.
- Reset mid-flight: grant req 1, then pull `rst_n` low one cycle later for 1 cycle.
  - Expect no `o_rsp_valid`, `o_mem_idx`=0, and the next grant to the lowest eligible requester.
